// File: rtl/fifo_rr_read_arbiter.sv
// fifo_rr_read_arbiter
// Round-robin read scheduler. It drains a bank of input fifos into one shared
// downstream fifo and pops at most one input per cycle. Each read goes through
// a short pipeline:
//   grant decision -> Fifo_rd (registered) -> lane capture -> out_wr/out_data
// New grants stop while the downstream fifo reports almost_full. The reads
// already issued still complete, and the downstream almost_full threshold
// leaves room for them.

module fifo_rr_read_arbiter #(
    parameter int BITNUMBER = 8,
    parameter int N_FIFOS   = 4,
    parameter int CNT_W     = 16,
    localparam int IDX_W    = $clog2(N_FIFOS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [N_FIFOS-1:0]             Fifo_empty,
    input  logic [N_FIFOS-1:0]             almost_empty,
    input  logic [N_FIFOS*BITNUMBER-1:0]   Fifo_Data_out,
    output logic [N_FIFOS-1:0]             Fifo_rd,
    input  logic                           out_almost_full,
    input  logic                           out_full,
    output logic                           out_wr,
    output logic [BITNUMBER-1:0]           out_data,
    output logic [IDX_W-1:0]               grant_idx,
    output logic                           busy,
    output logic [CNT_W-1:0]               word_cnt,
    output logic                           ovf_error
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STALL
    } state_t;

    state_t                 state;
    logic [IDX_W-1:0]       rr_ptr;
    logic                   pend_valid;
    logic [IDX_W-1:0]       pend_idx;

    logic [N_FIFOS-1:0]     eligible;
    logic                   any_eligible;
    logic                   grant_found;
    logic [IDX_W-1:0]       grant_sel;
    logic                   grant_fire;
    logic [BITNUMBER-1:0]   lane_data [N_FIFOS];

    // An input is eligible when it holds data. If it is being read this cycle
    // and holds only that one word, it is not eligible: its empty flag has not
    // caught up with the read yet.
    always_comb begin
        eligible = ~Fifo_empty & ~(Fifo_rd & almost_empty);
    end

    assign any_eligible = |eligible;

    // Search for the first eligible input after the rr pointer, wrapping
    // from the last index back to 0.
    always_comb begin
        logic [IDX_W:0] sum;
        logic [IDX_W-1:0] cand;
        grant_found = 1'b0;
        grant_sel   = rr_ptr;
        sum         = '0;
        cand        = '0;
        for (int k = 1; k <= N_FIFOS; k++) begin
            sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(N_FIFOS)) begin
                sum = sum - (IDX_W+1)'(N_FIFOS);
            end
            cand = sum[IDX_W-1:0];
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_sel   = cand;
            end
        end
    end

    assign grant_fire = (state == RUN) && enable && !out_almost_full && grant_found;

    // Split the packed input bus into one word per lane for indexed capture.
    always_comb begin
        for (int i = 0; i < N_FIFOS; i++) begin
            lane_data[i] = Fifo_Data_out[i*BITNUMBER +: BITNUMBER];
        end
    end

    // Control FSM, read strobe, capture pipeline, counter and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= IDX_W'(N_FIFOS - 1);
            Fifo_rd    <= '0;
            grant_idx  <= '0;
            pend_valid <= 1'b0;
            pend_idx   <= '0;
            out_wr     <= 1'b0;
            out_data   <= '0;
            word_cnt   <= '0;
            ovf_error  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (enable && any_eligible && !out_almost_full) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (out_almost_full) begin
                        state <= STALL;
                    end else if (!enable || !any_eligible) begin
                        state <= IDLE;
                    end
                end
                STALL: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (!out_almost_full && any_eligible) begin
                        state <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase

            Fifo_rd <= '0;
            if (grant_fire) begin
                Fifo_rd[grant_sel] <= 1'b1;
                rr_ptr             <= grant_sel;
                grant_idx          <= grant_sel;
            end

            pend_valid <= |Fifo_rd;
            if (|Fifo_rd) begin
                pend_idx <= grant_idx;
            end

            out_wr <= pend_valid;
            if (pend_valid) begin
                out_data <= lane_data[pend_idx];
            end

            if (out_wr) begin
                word_cnt <= word_cnt + 1'b1;
                if (out_full) begin
                    ovf_error <= 1'b1;
                end
            end
        end
    end

    assign busy = (state == RUN) || (|Fifo_rd) || pend_valid || out_wr;

endmodule

// File: tb/tb_fifo_rr_read_arbiter.sv
// tb_fifo_rr_read_arbiter
// Directed bench for the round-robin read arbiter. Four behavioural input
// fifos feed the DUT. Each expected output word is queued when its data is
// loaded, and the monitor pops and compares one entry for every out_wr.

module tb_fifo_rr_read_arbiter;

    localparam int BW = 8;
    localparam int NF = 4;
    localparam int CW = 16;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic [NF-1:0]     Fifo_empty = '1;
    logic [NF-1:0]     almost_empty = '1;
    logic [NF*BW-1:0]  Fifo_Data_out = '0;
    logic [NF-1:0]     Fifo_rd;
    logic              out_almost_full = 1'b0;
    logic              out_full = 1'b0;
    logic              out_wr;
    logic [BW-1:0]     out_data;
    logic [IW-1:0]     grant_idx;
    logic              busy;
    logic [CW-1:0]     word_cnt;
    logic              ovf_error;

    logic [BW-1:0]     lane_q [NF][$];
    logic [BW-1:0]     exp_q [$];

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int wr_count = 0;
    int first_wr_cycle = -1;
    int last_wr_cycle = -1;
    int last_rd_cycle = -1;
    int rd_count [NF] = '{default: 0};
    int exp_cnt = 0;

    fifo_rr_read_arbiter #(
        .BITNUMBER(BW),
        .N_FIFOS(NF),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .Fifo_empty(Fifo_empty),
        .almost_empty(almost_empty),
        .Fifo_Data_out(Fifo_Data_out),
        .Fifo_rd(Fifo_rd),
        .out_almost_full(out_almost_full),
        .out_full(out_full),
        .out_wr(out_wr),
        .out_data(out_data),
        .grant_idx(grant_idx),
        .busy(busy),
        .word_cnt(word_cnt),
        .ovf_error(ovf_error)
    );

    always #5 clk = ~clk;

    // Behavioural input fifos: pop on Fifo_rd, present the word and refresh the flags after the edge.
    always @(posedge clk) begin
        logic [NF*BW-1:0] dnext;
        logic [NF-1:0] e_n;
        logic [NF-1:0] ae_n;
        dnext = Fifo_Data_out;
        for (int i = 0; i < NF; i++) begin
            if (Fifo_rd[i]) begin
                checks++;
                assert (lane_q[i].size() != 0) else begin
                    errors++;
                    $error("[TB] FAIL underflow lane %0d observed_size=%0d required=nonzero", i, lane_q[i].size());
                end
                if (lane_q[i].size() != 0) begin
                    dnext[i*BW +: BW] = lane_q[i].pop_front();
                end
            end
        end
        for (int i = 0; i < NF; i++) begin
            e_n[i]  = (lane_q[i].size() == 0);
            ae_n[i] = (lane_q[i].size() <= 1);
        end
        Fifo_Data_out <= dnext;
        Fifo_empty    <= e_n;
        almost_empty  <= ae_n;
    end

    // Output monitor: one-hot read strobe, read bookkeeping and the scoreboard compare on each out_wr.
    always @(negedge clk) begin
        logic [BW-1:0] exp_word;
        cycle++;
        if (Fifo_rd != '0) begin
            checks++;
            assert ($onehot(Fifo_rd)) else begin
                errors++;
                $error("[TB] FAIL rd_onehot observed=%b required=one-hot", Fifo_rd);
            end
            for (int i = 0; i < NF; i++) begin
                if (Fifo_rd[i]) begin
                    rd_count[i]++;
                    last_rd_cycle = cycle;
                end
            end
        end
        if (out_wr) begin
            wr_count++;
            if (first_wr_cycle < 0) begin
                first_wr_cycle = cycle;
            end
            last_wr_cycle = cycle;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("[TB] FAIL unexpected_wr observed=%0h required=no write", out_data);
            end
            if (exp_q.size() != 0) begin
                exp_word = exp_q.pop_front();
                checks++;
                assert (out_data === exp_word) else begin
                    errors++;
                    $error("[TB] FAIL out_data observed=%0h expected=%0h", out_data, exp_word);
                end
            end
        end
    end

    // Hard time limit in case the whole run stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [BW-1:0] word_val(input int phase, input int lane, input int idx);
        return BW'((phase << 6) | (lane << 4) | idx);
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic wait_rd(input int limit, input string tag);
        int n;
        n = 0;
        while (Fifo_rd == '0 && n < limit) begin
            step();
            n++;
        end
        check_output(tag, 32'(Fifo_rd != '0), 32'd1);
    endtask

    task automatic wait_wr(input int target, input int limit, input string tag);
        int n;
        n = 0;
        while (wr_count < target && n < limit) begin
            step();
            n++;
        end
        check_output(tag, 32'(wr_count >= target), 32'd1);
    endtask

    function automatic int rd_total();
        int s;
        s = 0;
        for (int i = 0; i < NF; i++) begin
            s += rd_count[i];
        end
        return s;
    endfunction

    initial begin
        int base;
        int saved;
        int rd_saved;

        // Reset with every lane holding three words, then drain them in round-robin order.
        reset = 1'b1;
        enable = 1'b1;
        for (int lane = 0; lane < NF; lane++) begin
            for (int j = 0; j < 3; j++) begin
                lane_q[lane].push_back(word_val(0, lane, j));
            end
        end
        for (int j = 0; j < 3; j++) begin
            for (int lane = 0; lane < NF; lane++) begin
                exp_q.push_back(word_val(0, lane, j));
                exp_cnt++;
            end
        end
        step();
        step();
        check_output("rst_fifo_rd", 32'(Fifo_rd), 32'd0);
        check_output("rst_out_wr", 32'(out_wr), 32'd0);
        check_output("rst_out_data", 32'(out_data), 32'd0);
        check_output("rst_grant_idx", 32'(grant_idx), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_word_cnt", 32'(word_cnt), 32'd0);
        check_output("rst_ovf", 32'(ovf_error), 32'd0);
        reset = 1'b0;
        wait_rd(10, "first_grant_timeout");
        check_output("first_grant", 32'(Fifo_rd), 32'h1);
        check_output("first_grant_idx", 32'(grant_idx), 32'd0);
        wait_wr(12, 40, "stream12_timeout");
        repeat (3) step();
        check_output("stream12_span", 32'(last_wr_cycle - first_wr_cycle), 32'd11);
        check_output("stream12_cnt", 32'(word_cnt), 32'(exp_cnt));
        check_output("stream12_drained", 32'(exp_q.size()), 32'd0);
        check_output("stream12_busy", 32'(busy), 32'd0);

        // Single word on lane 2: exactly one read, written two cycles later.
        base = wr_count;
        rd_saved = rd_count[2];
        lane_q[2].push_back(word_val(1, 2, 0));
        exp_q.push_back(word_val(1, 2, 0));
        exp_cnt++;
        wait_wr(base + 1, 20, "single_timeout");
        repeat (4) step();
        check_output("single_rd_pulses", 32'(rd_count[2] - rd_saved), 32'd1);
        check_output("single_latency", 32'(last_wr_cycle - last_rd_cycle), 32'd2);
        check_output("single_cnt", 32'(word_cnt), 32'(exp_cnt));

        // Four words per lane with almost_full pulsed mid-stream. The pointer is at lane 2, so lane 3 goes first.
        base = wr_count;
        for (int lane = 0; lane < NF; lane++) begin
            for (int j = 0; j < 4; j++) begin
                lane_q[lane].push_back(word_val(2, lane, j));
            end
        end
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k < NF; k++) begin
                exp_q.push_back(word_val(2, (3 + k) % NF, j));
                exp_cnt++;
            end
        end
        wait_wr(base + 3, 20, "af_start_timeout");
        out_almost_full = 1'b1;
        saved = wr_count;
        step();
        check_output("af_rd_stop", 32'(Fifo_rd), 32'd0);
        rd_saved = rd_total();
        repeat (5) step();
        check_output("af_inflight_wr", 32'(wr_count - saved), 32'd2);
        check_output("af_no_new_rd", 32'(rd_total()), 32'(rd_saved));
        out_almost_full = 1'b0;
        wait_wr(base + 16, 60, "af_resume_timeout");
        repeat (3) step();
        check_output("af_cnt", 32'(word_cnt), 32'(exp_cnt));
        check_output("af_drained", 32'(exp_q.size()), 32'd0);

        // out_full while a word is in flight sets the sticky overflow flag.
        check_output("ovf_before", 32'(ovf_error), 32'd0);
        base = wr_count;
        lane_q[1].push_back(word_val(3, 1, 0));
        exp_q.push_back(word_val(3, 1, 0));
        exp_cnt++;
        wait_rd(20, "ovf_rd_timeout");
        out_full = 1'b1;
        wait_wr(base + 1, 10, "ovf_wr_timeout");
        step();
        out_full = 1'b0;
        check_output("ovf_set", 32'(ovf_error), 32'd1);
        repeat (5) step();
        check_output("ovf_sticky", 32'(ovf_error), 32'd1);
        check_output("ovf_cnt", 32'(word_cnt), 32'(exp_cnt));

        // Reset with two reads in flight: both are dropped and nothing is written afterwards.
        for (int j = 0; j < 2; j++) begin
            lane_q[0].push_back(word_val(3, 0, j + 4));
            lane_q[1].push_back(word_val(3, 1, j + 4));
        end
        wait_rd(20, "rst_flight_rd_timeout");
        step();
        check_output("rst_flight_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        enable = 1'b0;
        exp_q.delete();
        step();
        step();
        reset = 1'b0;
        check_output("rst_flight_cnt", 32'(word_cnt), 32'd0);
        check_output("rst_flight_ovf", 32'(ovf_error), 32'd0);
        check_output("rst_flight_busy0", 32'(busy), 32'd0);
        saved = wr_count;
        rd_saved = rd_total();
        repeat (6) step();
        check_output("rst_flight_no_wr", 32'(wr_count), 32'(saved));
        check_output("rst_flight_no_rd", 32'(rd_total()), 32'(rd_saved));
        check_output("rst_flight_cnt_hold", 32'(word_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
